// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 receiver with memory-mapped read port.
// Holds the deframer state enum, the default register addresses and the STATUS bit layout.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    localparam logic [31:0] DEF_ADDR_DATA   = 32'd4099;
    localparam logic [31:0] DEF_ADDR_STATUS = 32'd4100;

    localparam int ST_AVAIL   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_CNT_LSB = 4;

    // Eight data bits plus the parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx_mmio_if.sv
// CPU dmem read-port bundle: the CPU drives address and read strobe,
// the peripheral answers with its hit flag and read word.
interface ps2_rx_mmio_if;
    logic [31:0] addr;
    logic        rd_strobe;
    logic        hit;
    logic [31:0] rd_data;

    modport master (output addr, output rd_strobe, input hit, input rd_data);
    modport slave  (input addr, input rd_strobe, output hit, output rd_data);
endinterface

// File: rtl/ps2_rx_fifo.sv
// Small synchronous byte FIFO. A pop in the same cycle frees room for a push into a full FIFO;
// a push that still finds no room is dropped and flagged on o_ovf for that cycle.
module ps2_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_pop_ok;
    logic          w_push_ok;
    logic [CW-1:0] w_count_next;

    assign w_pop_ok  = i_pop & ~r_empty;
    assign w_push_ok = i_push & (~r_full | w_pop_ok);
    assign o_ovf     = i_push & ~w_push_ok;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: rtl/ps2_rx_mmio.sv
// PS/2 device-to-host receiver: conditions the lines, deframes 11-bit frames,
// queues good bytes and serves DATA/STATUS words on the CPU dmem read port.
module ps2_rx_mmio
    import ps2_rx_pkg::*;
#(
    parameter int          FILTER_CYCLES  = 8,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [31:0] ADDR_DATA      = DEF_ADDR_DATA,
    parameter logic [31:0] ADDR_STATUS    = DEF_ADDR_STATUS
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_ps2_clk,
    input  logic          i_ps2_data,
    ps2_rx_mmio_if.slave  bus,
    output logic          o_rx_avail
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] w_sync;

    // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic r_s1;
        logic r_s2;
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
            end else begin
                r_s1 <= (gi == 0) ? i_ps2_clk : i_ps2_data;
                r_s2 <= r_s1;
            end
        end
        assign w_sync[gi] = r_s2;
    end

    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_event;
    logic          w_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (w_sync[0] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_CYCLES - 1)) begin
                r_filt <= w_sync[0];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_event = r_filt_d & ~r_filt;
    assign w_data  = w_sync[1];

    rx_state_t     r_state,  w_state_next;
    logic [2:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_shreg,  w_shreg_next;
    logic          r_par_ok, w_par_ok_next;
    logic [TW-1:0] r_tmo,    w_tmo_next;
    logic          w_push_req;
    logic          w_ferr_set;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par_ok <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_bitcnt <= w_bitcnt_next;
            r_shreg  <= w_shreg_next;
            r_par_ok <= w_par_ok_next;
            r_tmo    <= w_tmo_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_bitcnt_next = r_bitcnt;
        w_shreg_next  = r_shreg;
        w_par_ok_next = r_par_ok;
        w_tmo_next    = (r_state == S_IDLE || w_event) ? '0 : r_tmo + TW'(1);
        w_push_req    = 1'b0;
        w_ferr_set    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_event && !w_data) begin
                    w_state_next  = S_DATA;
                    w_bitcnt_next = '0;
                end
            end
            S_DATA: begin
                if (w_event) begin
                    w_shreg_next  = {w_data, r_shreg[7:1]};
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_event) begin
                    w_par_ok_next = odd_parity_ok({r_shreg, w_data});
                    w_state_next  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_event) begin
                    if (w_data && r_par_ok) w_push_req = 1'b1;
                    else                    w_ferr_set = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // A stalled frame is abandoned so the receiver can catch the next start bit.
        if (r_state != S_IDLE && !w_event && r_tmo >= TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_next  = S_IDLE;
            w_bitcnt_next = '0;
            w_shreg_next  = '0;
            w_tmo_next    = '0;
            w_ferr_set    = 1'b1;
        end
    end

    logic          r_push;
    logic [7:0]    r_push_byte;
    logic          r_ovf;
    logic          r_ferr;
    logic          w_pop;
    logic          w_st_rd;
    logic [7:0]    w_head;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic          w_ovf_set;

    assign w_pop   = bus.rd_strobe && (bus.addr == ADDR_DATA);
    assign w_st_rd = bus.rd_strobe && (bus.addr == ADDR_STATUS);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_ovf       <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_push      <= w_push_req;
            r_push_byte <= r_shreg;
            r_ovf       <= w_ovf_set  | (r_ovf  & ~w_st_rd);
            r_ferr      <= w_ferr_set | (r_ferr & ~w_st_rd);
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (r_push),
        .i_data    (r_push_byte),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count),
        .o_ovf     (w_ovf_set)
    );

    assign o_rx_avail = ~w_empty;

    always_comb begin
        bus.hit     = (bus.addr == ADDR_DATA) || (bus.addr == ADDR_STATUS);
        bus.rd_data = '0;
        if (bus.addr == ADDR_DATA) begin
            if (!w_empty) bus.rd_data = {23'd0, 1'b1, w_head};
        end else if (bus.addr == ADDR_STATUS) begin
            bus.rd_data[ST_AVAIL]            = ~w_empty;
            bus.rd_data[ST_FULL]             = w_full;
            bus.rd_data[ST_OVF]              = r_ovf;
            bus.rd_data[ST_FERR]             = r_ferr;
            bus.rd_data[ST_CNT_LSB +: CW]    = w_count;
        end
    end

endmodule

// File: tb/tb_ps2_rx_mmio.sv
// Directed and randomized checks of the PS/2 receiver against a byte-queue model of the
// FIFO and sticky flags; frames are bit-banged onto the PS/2 lines.
module tb_ps2_rx_mmio;
    localparam logic [31:0] A_DATA   = 32'd4099;
    localparam logic [31:0] A_STATUS = 32'd4100;
    localparam int          HALF     = 50;
    localparam int          DEPTH    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic rx_avail;

    ps2_rx_mmio_if bus_if ();

    ps2_rx_mmio #(
        .FILTER_CYCLES  (8),
        .TIMEOUT_CYCLES (400),
        .FIFO_DEPTH     (DEPTH),
        .ADDR_DATA      (A_DATA),
        .ADDR_STATUS    (A_STATUS)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .bus        (bus_if),
        .o_rx_avail (rx_avail)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    bit m_ovf = 0;
    bit m_ferr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_glitch();
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; optionally a 3-cycle low glitch in one bit's high phase.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {1'b1, ~(^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                tick(10);
                clk_glitch();
                tick(HALF - 13);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad_par);
        if (bad_par)              m_ferr = 1;
        else if (q.size() < DEPTH) q.push_back(d);
        else                      m_ovf = 1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, 1'b0, 11, -1);
        model_frame(d, 1'b0);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic strobe, output logic [31:0] d, output logic h);
        bus_if.addr      = a;
        bus_if.rd_strobe = strobe;
        @(negedge clk);
        d = bus_if.rd_data;
        h = bus_if.hit;
        @(posedge clk);
        #1;
        bus_if.rd_strobe = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [3:0] cnt;
        cnt = 4'(q.size());
        return {24'd0, cnt, m_ferr, m_ovf, (q.size() == DEPTH), (q.size() != 0)};
    endfunction

    function automatic logic [31:0] exp_data();
        return (q.size() != 0) ? {23'd0, 1'b1, q[0]} : 32'd0;
    endfunction

    task automatic rd_data_chk(input string tag, input logic strobe);
        logic [31:0] d, e;
        logic h;
        e = exp_data();
        bus_read(A_DATA, strobe, d, h);
        chk({tag, ".data"}, d, e);
        chk({tag, ".hit"}, {31'd0, h}, 32'd1);
        if (strobe && q.size() != 0) void'(q.pop_front());
        $display("read DATA strobe=%0d -> %h (exp %h)", strobe, d, e);
    endtask

    task automatic rd_status_chk(input string tag, input logic strobe);
        logic [31:0] d, e;
        logic h;
        e = exp_status();
        bus_read(A_STATUS, strobe, d, h);
        chk({tag, ".status"}, d, e);
        chk({tag, ".hit"}, {31'd0, h}, 32'd1);
        if (strobe) begin
            m_ovf = 0;
            m_ferr = 0;
        end
        $display("read STATUS strobe=%0d -> %h (exp %h)", strobe, d, e);
    endtask

    task automatic rd_miss_chk(input string tag, input logic [31:0] a);
        logic [31:0] d;
        logic h;
        bus_read(a, 1'b1, d, h);
        chk({tag, ".miss_data"}, d, 32'd0);
        chk({tag, ".miss_hit"}, {31'd0, h}, 32'd0);
        $display("read %h (unmapped) -> %h hit=%0d", a, d, h);
    endtask

    task automatic avail_chk(input string tag);
        chk({tag, ".avail"}, {31'd0, rx_avail}, {31'd0, q.size() != 0});
    endtask

    initial begin
        bus_if.addr      = 32'd0;
        bus_if.rd_strobe = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);

        // Reset state
        avail_chk("reset");
        rd_status_chk("reset", 1'b0);
        rd_data_chk("reset", 1'b1);
        rd_miss_chk("reset", 32'd4098);

        // Good frame 0x1C
        good_frame(8'h1C);
        avail_chk("f1c");
        rd_status_chk("f1c", 1'b0);
        chk("f1c.status_const", exp_status(), 32'h11);
        rd_data_chk("f1c", 1'b1);
        tick(1);
        rd_status_chk("f1c_pop", 1'b1);

        // Bad parity
        send_frame(8'h1C, 1'b1, 11, -1);
        model_frame(8'h1C, 1'b1);
        avail_chk("par");
        rd_status_chk("par1", 1'b1);
        rd_status_chk("par2", 1'b1);

        // Overflow: nine frames, no reads
        for (int i = 1; i <= 9; i++) good_frame(8'(i));
        avail_chk("ovf");
        rd_status_chk("ovf", 1'b1);
        for (int i = 0; i < 8; i++) rd_data_chk("ovf_drain", 1'b1);
        rd_data_chk("ovf_empty", 1'b1);
        rd_status_chk("ovf_after", 1'b0);

        // Timeout mid-frame
        send_frame(8'h00, 1'b0, 5, -1);
        tick(1000);
        m_ferr = 1;
        rd_status_chk("tmo", 1'b1);
        good_frame(8'hF0);
        rd_data_chk("tmo_next", 1'b1);

        // Clock glitches at idle and mid-frame
        clk_glitch();
        tick(40);
        rd_status_chk("glitch_idle", 1'b0);
        send_frame(8'h5A, 1'b0, 11, 4);
        model_frame(8'h5A, 1'b0);
        rd_status_chk("glitch", 1'b0);
        rd_data_chk("glitch", 1'b1);

        // Reset mid-frame with a queued byte
        good_frame(8'h33);
        send_frame(8'h00, 1'b0, 5, -1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        q.delete();
        m_ovf = 0;
        m_ferr = 0;
        tick(20);
        avail_chk("rst_mid");
        rd_status_chk("rst_mid", 1'b0);
        good_frame(8'hAA);
        rd_data_chk("rst_next", 1'b1);

        // Randomized frames and reads
        for (int it = 0; it < 24; it++) begin
            logic [7:0] d;
            bit bp;
            int nops;
            d = 8'($urandom);
            bp = ($urandom_range(0, 4) == 0);
            send_frame(d, bp, 11, -1);
            model_frame(d, bp);
            avail_chk("rnd");
            nops = $urandom_range(0, 2);
            for (int k = 0; k < nops; k++) begin
                case ($urandom_range(0, 3))
                    0: rd_data_chk("rnd", 1'b1);
                    1: rd_data_chk("rnd_peek", 1'b0);
                    2: rd_status_chk("rnd", 1'b1);
                    default: rd_miss_chk("rnd", 32'd4101 + 32'($urandom_range(0, 7)));
                endcase
            end
        end
        rd_status_chk("final", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
